// File: rtl/bm_bridge_pkg.sv
// Shared types and constants for the BondMachine host port bridge.
package bm_bridge_pkg;

    localparam int STATS_W = 16;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_WAIT = 2'd1,
        T_REL  = 2'd2
    } tx_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rx_state_t;

    function automatic logic [STATS_W-1:0] stat_inc(input logic [STATS_W-1:0] cnt);
        return cnt + 16'd1;
    endfunction

endpackage

// File: rtl/bm_bridge_fifo.sv
// Synchronous FIFO with wrap-bit pointers and full/empty flags; the read
// port shows zero while empty so downstream data is clean after reset.
module bm_bridge_fifo
    import bm_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock_signal,
    input  logic             reset_signal,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values; push and pop advance independently.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clock_signal or negedge reset_signal) begin
        if (!reset_signal) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock_signal) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/bm_port_bridge.sv
// Host endpoint for one BondMachine i-port/o-port pair using 4-phase valid/received.
// Define BM_BRIDGE_STATS_EN to add 16-bit tx_count/rx_count transfer counters.
module bm_port_bridge
    import bm_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clock_signal,
    input  logic               reset_signal,
    input  logic [WIDTH-1:0]   tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [WIDTH-1:0]   rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [WIDTH-1:0]   bm_i,
    output logic               bm_i_valid,
    input  logic               bm_i_received,
    input  logic [WIDTH-1:0]   bm_o,
    input  logic               bm_o_valid,
    output logic               bm_o_received
`ifdef BM_BRIDGE_STATS_EN
    ,
    output logic [STATS_W-1:0] tx_count,
    output logic [STATS_W-1:0] rx_count
`endif
);

    tx_state_t        tx_state_q, tx_state_d;
    rx_state_t        rx_state_q, rx_state_d;
    logic [WIDTH-1:0] bm_i_q, bm_i_d;
    logic             bm_i_valid_q, bm_i_valid_d;
    logic             bm_o_received_q, bm_o_received_d;

    logic             tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;
    logic [WIDTH-1:0] tx_head_s;
    logic             rx_full_s, rx_empty_s, rx_push_s, rx_pop_s;

    assign tx_ready      = !tx_full_s;
    assign tx_push_s     = tx_valid && !tx_full_s;
    assign rx_valid      = !rx_empty_s;
    assign rx_pop_s      = rx_ready && !rx_empty_s;
    assign bm_i          = bm_i_q;
    assign bm_i_valid    = bm_i_valid_q;
    assign bm_o_received = bm_o_received_q;

    bm_bridge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clock_signal (clock_signal),
        .reset_signal (reset_signal),
        .push         (tx_push_s),
        .push_data    (tx_data),
        .pop          (tx_pop_s),
        .pop_data     (tx_head_s),
        .full         (tx_full_s),
        .empty        (tx_empty_s)
    );

    bm_bridge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clock_signal (clock_signal),
        .reset_signal (reset_signal),
        .push         (rx_push_s),
        .push_data    (bm_o),
        .pop          (rx_pop_s),
        .pop_data     (rx_data),
        .full         (rx_full_s),
        .empty        (rx_empty_s)
    );

    // Transmitter: the head word stays in the FIFO until the processor acknowledges it.
    always_comb begin
        tx_state_d   = tx_state_q;
        bm_i_d       = bm_i_q;
        bm_i_valid_d = bm_i_valid_q;
        tx_pop_s     = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                bm_i_valid_d = 1'b0;
                if (!tx_empty_s) begin
                    bm_i_d       = tx_head_s;
                    bm_i_valid_d = 1'b1;
                    tx_state_d   = T_WAIT;
                end else begin
                    tx_state_d   = T_IDLE;
                end
            end
            T_WAIT: begin
                if (bm_i_received) begin
                    bm_i_valid_d = 1'b0;
                    tx_pop_s     = 1'b1;
                    tx_state_d   = T_REL;
                end else begin
                    tx_state_d   = T_WAIT;
                end
            end
            T_REL: begin
                if (!bm_i_received) begin
                    tx_state_d = T_IDLE;
                end else begin
                    tx_state_d = T_REL;
                end
            end
            default: begin
                bm_i_valid_d = 1'b0;
                tx_state_d   = T_IDLE;
            end
        endcase
    end

    // Receiver: a full RX FIFO withholds the acknowledge, so nothing is dropped.
    always_comb begin
        rx_state_d       = rx_state_q;
        bm_o_received_d  = bm_o_received_q;
        rx_push_s        = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (bm_o_valid && !rx_full_s) begin
                    rx_push_s       = 1'b1;
                    bm_o_received_d = 1'b1;
                    rx_state_d      = R_ACK;
                end else begin
                    bm_o_received_d = 1'b0;
                    rx_state_d      = R_IDLE;
                end
            end
            R_ACK: begin
                if (!bm_o_valid) begin
                    bm_o_received_d = 1'b0;
                    rx_state_d      = R_IDLE;
                end else begin
                    bm_o_received_d = 1'b1;
                    rx_state_d      = R_ACK;
                end
            end
            default: begin
                bm_o_received_d = 1'b0;
                rx_state_d      = R_IDLE;
            end
        endcase
    end

    // Handshake state and registered port outputs.
    always_ff @(posedge clock_signal or negedge reset_signal) begin
        if (!reset_signal) begin
            tx_state_q      <= T_IDLE;
            rx_state_q      <= R_IDLE;
            bm_i_q          <= {WIDTH{1'b0}};
            bm_i_valid_q    <= 1'b0;
            bm_o_received_q <= 1'b0;
        end else begin
            tx_state_q      <= tx_state_d;
            rx_state_q      <= rx_state_d;
            bm_i_q          <= bm_i_d;
            bm_i_valid_q    <= bm_i_valid_d;
            bm_o_received_q <= bm_o_received_d;
        end
    end

`ifdef BM_BRIDGE_STATS_EN
    logic [STATS_W-1:0] tx_count_q, tx_count_d;
    logic [STATS_W-1:0] rx_count_q, rx_count_d;

    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;

    // Completed-transfer counters; wrap naturally at 16 bits.
    always_comb begin
        tx_count_d = tx_count_q;
        rx_count_d = rx_count_q;
        if (tx_pop_s) begin
            tx_count_d = stat_inc(tx_count_q);
        end else begin
            tx_count_d = tx_count_q;
        end
        if (rx_push_s) begin
            rx_count_d = stat_inc(rx_count_q);
        end else begin
            rx_count_d = rx_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clock_signal or negedge reset_signal) begin
        if (!reset_signal) begin
            tx_count_q <= {STATS_W{1'b0}};
            rx_count_q <= {STATS_W{1'b0}};
        end else begin
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_bm_port_bridge.sv
// Scoreboard bench for bm_port_bridge: directed protocol cases plus a randomized
// concurrent phase where expected words are queued at issue and popped by monitors.
module tb_bm_port_bridge;

    localparam int W = 8;
    localparam int D = 4;
    localparam int NRAND = 40;

    logic         clock_signal = 1'b0;
    logic         reset_signal = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready = 1'b0;
    logic [W-1:0] bm_i;
    logic         bm_i_valid;
    logic         bm_i_received = 1'b0;
    logic [W-1:0] bm_o = '0;
    logic         bm_o_valid = 1'b0;
    logic         bm_o_received;
`ifdef BM_BRIDGE_STATS_EN
    logic [15:0]  tx_count;
    logic [15:0]  rx_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];

    always #5 clock_signal = ~clock_signal;

    bm_port_bridge #(.WIDTH(W), .DEPTH(D)) dut (
        .clock_signal  (clock_signal),
        .reset_signal  (reset_signal),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .bm_i          (bm_i),
        .bm_i_valid    (bm_i_valid),
        .bm_i_received (bm_i_received),
        .bm_o          (bm_o),
        .bm_o_valid    (bm_o_valid),
        .bm_o_received (bm_o_received)
`ifdef BM_BRIDGE_STATS_EN
        ,
        .tx_count      (tx_count),
        .rx_count      (rx_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_ready"}, tx_ready, 1);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_rx_data"}, rx_data, 0);
        chk({tag, "_bm_i"}, bm_i, 0);
        chk({tag, "_bm_i_valid"}, bm_i_valid, 0);
        chk({tag, "_bm_o_received"}, bm_o_received, 0);
    endtask

    // All directed tasks start and end just after a falling edge.
    task automatic push_tx(input logic [W-1:0] w);
        tx_valid = 1'b1;
        tx_data  = w;
        @(negedge clock_signal);
        tx_valid = 1'b0;
    endtask

    task automatic take_tx(input logic [W-1:0] exp, input string name);
        int n = 0;
        while (!bm_i_valid && n < 20) begin
            @(negedge clock_signal);
            n++;
        end
        chk({name, "_valid"}, bm_i_valid, 1);
        chk({name, "_data"}, bm_i, exp);
        bm_i_received = 1'b1;
        @(negedge clock_signal);
        chk({name, "_release"}, bm_i_valid, 0);
        bm_i_received = 1'b0;
        @(negedge clock_signal);
    endtask

    task automatic send_rx(input logic [W-1:0] w);
        int n = 0;
        bm_o       = w;
        bm_o_valid = 1'b1;
        do begin
            @(negedge clock_signal);
            n++;
        end while (!bm_o_received && n < 20);
        chk("send_rx_ack", bm_o_received, 1);
        bm_o_valid = 1'b0;
        @(negedge clock_signal);
    endtask

    task automatic pop_rx(input logic [W-1:0] exp, input string name);
        chk({name, "_valid"}, rx_valid, 1);
        chk({name, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clock_signal);
        rx_ready = 1'b0;
    endtask

    // Random host writer: expected word is queued when the push is certain.
    task automatic host_tx_run(input int n);
        int sent = 0;
        while (sent < n) begin
            @(negedge clock_signal);
            if ($urandom_range(3, 0) != 0) begin
                tx_valid = 1'b1;
                tx_data  = W'($urandom);
                while (!tx_ready) @(negedge clock_signal);
                txq.push_back(tx_data);
                sent++;
            end else begin
                tx_valid = 1'b0;
            end
        end
        @(negedge clock_signal);
        tx_valid = 1'b0;
    endtask

    // Processor-side i-port monitor with random acknowledge latency.
    task automatic proc_tx_run(input int n);
        int got = 0;
        while (got < n) begin
            @(negedge clock_signal);
            if (bm_i_valid && $urandom_range(2, 0) != 0) begin
                chk("tx_queue_nonempty", (txq.size() != 0), 1);
                if (txq.size() != 0) chk("tx_word", bm_i, txq.pop_front());
                bm_i_received = 1'b1;
                @(negedge clock_signal);
                chk("tx_release", bm_i_valid, 0);
                repeat ($urandom_range(2, 0)) @(negedge clock_signal);
                bm_i_received = 1'b0;
                @(negedge clock_signal);
                chk("tx_gap", bm_i_valid, 0);
                got++;
            end
        end
    endtask

    // Processor-side o-port driver: each pulse is queued once, however long it is held.
    task automatic proc_rx_run(input int n);
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            repeat ($urandom_range(3, 0)) @(negedge clock_signal);
            bm_o       = W'($urandom);
            bm_o_valid = 1'b1;
            rxq.push_back(bm_o);
            do begin
                @(negedge clock_signal);
                waited++;
            end while (!bm_o_received && waited < 300);
            chk("rx_ack_seen", bm_o_received, 1);
            repeat ($urandom_range(3, 0)) @(negedge clock_signal);
            chk("rx_ack_hold", bm_o_received, 1);
            bm_o_valid = 1'b0;
            @(negedge clock_signal);
            chk("rx_ack_drop", bm_o_received, 0);
        end
    endtask

    // Host reader monitor with random backpressure.
    task automatic host_rx_run(input int n);
        int got = 0;
        while (got < n) begin
            @(negedge clock_signal);
            rx_ready = 1'($urandom_range(1, 0));
            if (rx_valid && rx_ready) begin
                chk("rx_queue_nonempty", (rxq.size() != 0), 1);
                if (rxq.size() != 0) chk("rx_word", rx_data, rxq.pop_front());
                got++;
            end
        end
        @(negedge clock_signal);
        rx_ready = 1'b0;
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog timeout at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock_signal);
        chk_reset_outputs("reset");
        reset_signal = 1'b1;
        @(negedge clock_signal);

        // Single word latency and release.
        push_tx(8'h5A);
        chk("push_lat_early", bm_i_valid, 0);
        @(negedge clock_signal);
        chk("push_lat_valid", bm_i_valid, 1);
        chk("push_lat_data", bm_i, 8'h5A);
        bm_i_received = 1'b1;
        @(negedge clock_signal);
        chk("ack_drop", bm_i_valid, 0);
        bm_i_received = 1'b0;
        repeat (4) @(negedge clock_signal);
        chk("tx_fifo_empty", bm_i_valid, 0);

        // TX fill and in-order drain.
        for (int k = 1; k <= 4; k++) begin
            tx_valid = 1'b1;
            tx_data  = W'(k);
            @(negedge clock_signal);
        end
        tx_valid = 1'b0;
        chk("tx_full_ready", tx_ready, 0);
        for (int k = 1; k <= 4; k++) begin
            take_tx(W'(k), "tx_order");
            if (k == 1) chk("tx_ready_after_pop", tx_ready, 1);
        end

        // Long valid pulse yields exactly one entry.
        bm_o       = 8'hC3;
        bm_o_valid = 1'b1;
        @(negedge clock_signal);
        chk("hold_ack", bm_o_received, 1);
        chk("hold_rx_valid", rx_valid, 1);
        chk("hold_rx_data", rx_data, 8'hC3);
        repeat (4) begin
            @(negedge clock_signal);
            chk("hold_ack_stays", bm_o_received, 1);
        end
        bm_o_valid = 1'b0;
        @(negedge clock_signal);
        chk("hold_ack_clear", bm_o_received, 0);
        pop_rx(8'hC3, "hold_pop");
        chk("hold_single_entry", rx_valid, 0);

        // RX full backpressure, then capture after one pop.
        send_rx(8'h11);
        send_rx(8'h22);
        send_rx(8'h33);
        send_rx(8'h44);
        bm_o       = 8'h55;
        bm_o_valid = 1'b1;
        repeat (3) begin
            @(negedge clock_signal);
            chk("full_no_ack", bm_o_received, 0);
        end
        pop_rx(8'h11, "full_pop");
        chk("full_no_ack_on_pop", bm_o_received, 0);
        @(negedge clock_signal);
        chk("full_capture_after_pop", bm_o_received, 1);
        bm_o_valid = 1'b0;
        @(negedge clock_signal);
        pop_rx(8'h22, "full_drain");
        pop_rx(8'h33, "full_drain");
        pop_rx(8'h44, "full_drain");
        pop_rx(8'h55, "full_drain");
        chk("full_drained", rx_valid, 0);

        // Asynchronous reset in the middle of a TX handshake.
        send_rx(8'h66);
        push_tx(8'h99);
        @(negedge clock_signal);
        chk("pre_reset_wait", bm_i_valid, 1);
        #2;
        reset_signal = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clock_signal);
        reset_signal = 1'b1;
        @(negedge clock_signal);

        // Randomized concurrent traffic against the queue scoreboards.
        fork
            host_tx_run(NRAND);
            proc_tx_run(NRAND);
            proc_rx_run(NRAND);
            host_rx_run(NRAND);
        join
        repeat (4) @(negedge clock_signal);
        chk("rand_txq_drained", txq.size(), 0);
        chk("rand_rxq_drained", rxq.size(), 0);
        chk("rand_rx_idle", rx_valid, 0);
        chk("rand_tx_idle", bm_i_valid, 0);

`ifdef BM_BRIDGE_STATS_EN
        reset_signal = 1'b0;
        @(negedge clock_signal);
        chk("stats_reset_tx", tx_count, 0);
        chk("stats_reset_rx", rx_count, 0);
        reset_signal = 1'b1;
        @(negedge clock_signal);
        for (int k = 0; k < 3; k++) begin
            push_tx(W'(8'hA0 + k));
            take_tx(W'(8'hA0 + k), "stats_tx");
        end
        for (int k = 0; k < 2; k++) begin
            send_rx(W'(8'hB0 + k));
            pop_rx(W'(8'hB0 + k), "stats_rx");
        end
        chk("stats_tx_count", tx_count, 3);
        chk("stats_rx_count", rx_count, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
